// File: rtl/car_pattern_gen.sv
// Parking-lot sensor pattern generator: emits the {a,b} sequences a car produces
// while entering or leaving, and keeps the emulated occupancy count.
module car_pattern_gen #(
   parameter int MAX  = 25,
   parameter int HOLD = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter_req,
   input  logic       exit_req,
   output logic       ready,
   output logic       a,
   output logic       b,
   output logic       done,
   output logic       reject,
   output logic [4:0] count,
   output logic       full,
   output logic       clear
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [4:0]    CNT_MAX   = 5'(MAX);

   typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, GAP} state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            dir_q, dir_d;        // 1 = enter path, 0 = exit path
   logic            a_q, a_d, b_q, b_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            reject_q, reject_d;
   logic [4:0]      count_q, count_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      hold_d   = hold_q;
      dir_d    = dir_q;
      reject_d = 1'b0;
      count_d  = count_q;
      a_d      = 1'b0;
      b_d      = 1'b0;

      if (state_q == IDLE) begin
         hold_d = '0;
         if (enter_req && exit_req) begin
            reject_d = 1'b1;
         end else if (enter_req) begin
            if (count_q == CNT_MAX) reject_d = 1'b1;
            else begin
               state_d = E1;
               dir_d   = 1'b1;
            end
         end else if (exit_req) begin
            if (count_q == 5'd0) reject_d = 1'b1;
            else begin
               state_d = X1;
               dir_d   = 1'b0;
            end
         end
      end else if (hold_q == HOLD_LAST) begin
         hold_d = '0;
         case (state_q)
            E1:      state_d = E2;
            E2:      state_d = E3;
            E3:      state_d = GAP;
            X1:      state_d = X2;
            X2:      state_d = X3;
            X3:      state_d = GAP;
            default: state_d = IDLE;
         endcase
      end else begin
         hold_d = hold_q + 1'b1;
      end

      // Outputs are computed from the next state so they land in registers.
      done_d  = (state_d == GAP) && (hold_d == HOLD_LAST);
      ready_d = (state_d == IDLE);
      if (done_d) count_d = dir_q ? count_q + 5'd1 : count_q - 5'd1;

      case (state_d)
         E1, X3:  a_d = 1'b1;
         E3, X1:  b_d = 1'b1;
         E2, X2:  begin a_d = 1'b1; b_d = 1'b1; end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         dir_q    <= 1'b0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         reject_q <= 1'b0;
         count_q  <= 5'd0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         dir_q    <= dir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         reject_q <= reject_d;
         count_q  <= count_d;
      end
   end

   assign a      = a_q;
   assign b      = b_q;
   assign ready  = ready_q;
   assign done   = done_q;
   assign reject = reject_q;
   assign count  = count_q;
   assign full   = (count_q == CNT_MAX);
   assign clear  = (count_q == 5'd0);

endmodule
